// File: rtl/stack_pkg.sv
// Shared types for the LIFO stack: occupancy states and operation codes.
// The helper function turns the raw {push,pop} request into an op code.
package stack_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_t;

  function automatic op_t decode_op(
    input logic push,
    input logic pop
  );
    op_t op;
    op = OP_NONE;
    unique case (1'b1)
      (push && !pop): op = OP_PUSH;
      (!push && pop): op = OP_POP;
      (push && pop):  op = OP_REPLACE;
      default:        op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_memory_if.sv
// Processor <-> stack bus: push/pop/data_in requests, top/flags back.
// count exists only when STACK_COUNT_EN is defined.
interface stack_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);

  localparam int SP_WIDTH = $clog2(DEPTH) + 1;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  error;
`ifdef STACK_COUNT_EN
  logic [SP_WIDTH-1:0]   count;
`endif

  modport master (
    output push,
    output pop,
    output data_in,
`ifdef STACK_COUNT_EN
    input  count,
`endif
    input  data_out,
    input  full,
    input  empty,
    input  error
  );

  modport slave (
    input  push,
    input  pop,
    input  data_in,
`ifdef STACK_COUNT_EN
    output count,
`endif
    output data_out,
    output full,
    output empty,
    output error
  );

endinterface

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x DATA_WIDTH, one sync write port, one async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). Never cleared.
module stack_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_memory.sv
// LIFO stack for the multicycle processor; top-of-stack is combinational.
// Ports: clk, reset (sync, active-high), bus (stack_memory_if.slave).
// Optional: STACK_COUNT_EN adds bus.count = occupancy (registered sp).
module stack_memory
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic           clk,
  input  logic           reset,
  stack_memory_if.slave  bus
);

  localparam int SP_WIDTH = $clog2(DEPTH) + 1;
  localparam int AW       = $clog2(DEPTH);
  localparam logic [SP_WIDTH-1:0] ONE = SP_WIDTH'(1);
  localparam logic [SP_WIDTH-1:0] MAX = SP_WIDTH'(DEPTH);

  state_t                state_q;
  state_t                state_d;
  logic [SP_WIDTH-1:0]   sp_q;
  logic [SP_WIDTH-1:0]   sp_d;
  logic                  err_q;
  logic                  err_d;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         push_addr;
  logic [AW-1:0]         top_addr;
  logic [SP_WIDTH-1:0]   sp_inc;
  logic [SP_WIDTH-1:0]   sp_dec;
  logic [DATA_WIDTH-1:0] rdata;
  op_t                   op;

  assign op        = decode_op(bus.push, bus.pop);
  assign sp_inc    = sp_q + ONE;
  assign sp_dec    = sp_q - ONE;
  assign push_addr = AW'(sp_q);
  assign top_addr  = AW'(sp_dec);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    err_d   = err_q;
    we      = 1'b0;
    waddr   = push_addr;
    unique case (state_q)
      ST_EMPTY: begin
        unique case (op)
          OP_PUSH: begin
            we      = 1'b1;
            sp_d    = sp_inc;
            state_d = ST_PARTIAL;
          end
          OP_POP: begin
            err_d = 1'b1;
          end
          // Nothing to replace: keep the push half, flag the pop half.
          OP_REPLACE: begin
            we      = 1'b1;
            sp_d    = sp_inc;
            state_d = ST_PARTIAL;
            err_d   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_PARTIAL: begin
        unique case (op)
          OP_PUSH: begin
            we   = 1'b1;
            sp_d = sp_inc;
            if (sp_inc == MAX) begin
              state_d = ST_FULL;
            end
          end
          OP_POP: begin
            sp_d = sp_dec;
            if (sp_dec == '0) begin
              state_d = ST_EMPTY;
            end
          end
          OP_REPLACE: begin
            we    = 1'b1;
            waddr = top_addr;
          end
          default: ;
        endcase
      end
      ST_FULL: begin
        unique case (op)
          OP_PUSH: begin
            err_d = 1'b1;
          end
          OP_POP: begin
            sp_d    = sp_dec;
            state_d = ST_PARTIAL;
          end
          OP_REPLACE: begin
            we    = 1'b1;
            waddr = top_addr;
          end
          default: ;
        endcase
      end
      default: begin
        state_d = ST_EMPTY;
        sp_d    = '0;
      end
    endcase
  end

  stack_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.data_in),
    .raddr (top_addr),
    .rdata (rdata)
  );

  // Stale array contents must never leak out of an empty stack.
  assign bus.data_out = (sp_q == '0) ? '0 : rdata;
  assign bus.full     = (state_q == ST_FULL);
  assign bus.empty    = (state_q == ST_EMPTY);
  assign bus.error    = err_q;

`ifdef STACK_COUNT_EN
  assign bus.count = sp_q;
`endif

endmodule

// File: tb/tb_stack_memory.sv
// Scoreboard bench for stack_memory: a queue model predicts outputs
// for each cycle; predictions are queued on drive, checked at negedge.
module tb_stack_memory;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          err;
    logic [4:0]    cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [DW-1:0] mdl [$];
  logic          merr;
  exp_t          expq [$];

  stack_memory_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  stack_memory #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.dout  = (mdl.size() == 0) ? '0 : mdl[mdl.size()-1];
    e.full  = (mdl.size() == DEPTH);
    e.empty = (mdl.size() == 0);
    e.err   = merr;
    e.cnt   = 5'(mdl.size());
    return e;
  endfunction

  task automatic model_step(input logic r, input logic p,
                            input logic q, input logic [DW-1:0] d);
    if (r) begin
      mdl.delete();
      merr = 1'b0;
    end else if (p && !q) begin
      if (mdl.size() < DEPTH) mdl.push_back(d);
      else merr = 1'b1;
    end else if (!p && q) begin
      if (mdl.size() > 0) void'(mdl.pop_back());
      else merr = 1'b1;
    end else if (p && q) begin
      if (mdl.size() == 0) begin
        mdl.push_back(d);
        merr = 1'b1;
      end else begin
        mdl[mdl.size()-1] = d;
      end
    end
  endtask

  // One cycle: drive, predict, check mid-cycle, clock, update model.
  task automatic cyc(input logic r, input logic p,
                     input logic q, input logic [DW-1:0] d);
    exp_t e;
    reset       = r;
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    expq.push_back(predict());
    @(negedge clk);
    e = expq.pop_front();
    chk("dout",  32'(bus.data_out), 32'(e.dout));
    chk("full",  32'(bus.full),     32'(e.full));
    chk("empty", 32'(bus.empty),    32'(e.empty));
    chk("error", 32'(bus.error),    32'(e.err));
`ifdef STACK_COUNT_EN
    chk("count", 32'(bus.count),    32'(e.cnt));
`endif
    @(posedge clk);
    #1;
    model_step(r, p, q, d);
    reset    = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef STACK_COUNT_EN
    chk(tag, 32'(bus.count), 32'(exp));
`else
    chk(tag, 32'(mdl.size()), 32'(exp));
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    merr   = 1'b0;
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_empty", 32'(bus.empty),    32'd1);
    chk("rst_full",  32'(bus.full),     32'd0);
    chk("rst_err",   32'(bus.error),    32'd0);
    chk("rst_dout",  32'(bus.data_out), 32'd0);

    // 1: basic push/push/pop
    cyc(0, 1, 0, 8'h11);
    cyc(0, 1, 0, 8'h22);
    chk("t1_dout",  32'(bus.data_out), 32'h22);
    chk("t1_empty", 32'(bus.empty),    32'd0);
    chk_cnt("t1_cnt", 2);
    cyc(0, 0, 1, 8'h00);
    chk("t1_pop", 32'(bus.data_out), 32'h11);
    cyc(0, 0, 1, 8'h00);

    // 2: fill, overflow, then 6: reset mid-push while full
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 8'(i));
    chk("t2_full", 32'(bus.full), 32'd1);
    cyc(0, 1, 0, 8'hAA);
    chk("t2_err",  32'(bus.error),    32'd1);
    chk("t2_dout", 32'(bus.data_out), 32'h0F);
    cyc(1, 1, 0, 8'h55);
    chk("t6_empty", 32'(bus.empty),    32'd1);
    chk("t6_full",  32'(bus.full),     32'd0);
    chk("t6_err",   32'(bus.error),    32'd0);
    chk("t6_dout",  32'(bus.data_out), 32'd0);
    chk_cnt("t6_cnt", 0);

    // full replace: stays full, no error
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 8'(8'h40 + i));
    cyc(0, 1, 1, 8'h5A);
    chk("fr_dout", 32'(bus.data_out), 32'h5A);
    chk("fr_full", 32'(bus.full),     32'd1);
    chk("fr_err",  32'(bus.error),    32'd0);
    cyc(1, 0, 0, 8'h00);

    // 3: underflow is sticky
    cyc(0, 0, 1, 8'h00);
    chk("t3_err",   32'(bus.error),    32'd1);
    chk("t3_empty", 32'(bus.empty),    32'd1);
    chk("t3_dout",  32'(bus.data_out), 32'd0);
    cyc(0, 1, 0, 8'h05);
    chk("t3_dout2", 32'(bus.data_out), 32'h05);
    chk("t3_err2",  32'(bus.error),    32'd1);
    cyc(1, 0, 0, 8'h00);

    // 4: replace top
    cyc(0, 1, 0, 8'h03);
    cyc(0, 1, 0, 8'h07);
    cyc(0, 1, 1, 8'h09);
    chk("t4_dout", 32'(bus.data_out), 32'h09);
    chk("t4_err",  32'(bus.error),    32'd0);
    chk_cnt("t4_cnt", 2);
    cyc(1, 0, 0, 8'h00);

    // 5: two back-to-back pops; scoreboard checks 07 then 03
    cyc(0, 1, 0, 8'h03);
    cyc(0, 1, 0, 8'h07);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 1, 8'h00);
    chk("t5_empty", 32'(bus.empty), 32'd1);

    // empty + push+pop: push half kept, error flagged
    cyc(0, 1, 1, 8'h66);
    chk("ep_dout", 32'(bus.data_out), 32'h66);
    chk("ep_err",  32'(bus.error),    32'd1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
          8'($urandom));
    end
    cyc(0, 0, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
